execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage MIPS pipeline: operand bypass, ALU, late-branch resolution and destination selection. It sits between register fetch and MEM. It consumes the instruction, PC and raw register values aligned to the ALU stage. It produces registered results for MEM/writeback and a combinational late-branch redirect for fetch. It also contains the parameterised register delay line used to align side-band signals.

## Interface
Parameters:
- RESET_PC_LINK, 0: reset value of rd_value.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst  in  32  instruction in ALU stage
- pc  in  32  PC of inst
- rs_val, rt_val  in  32 each  regfile read data for inst[25:21], inst[20:16]
- regwrite_enable  in  1  inst writes a register
- memread_enable  in  1  inst is a load
- rs_override_rd, rt_override_rd  in  1 each  destination select
- const_override_rs  in  1  shift amount from inst[10:6] instead of rs[4:0]
- const_override_rt  in  1  operand B = immediate
- squash  in  1  inst is wrong-path; kill it
- rd_index  out  5  registered destination (0 = no write)
- rd_value  out  32  registered result / memory address
- rt_val_d1  out  32  registered bypassed rt (store data)
- memop_disable  out  1  registered; MEM must ignore load/store
- alu_exception  out  3  registered exception code
- br_late_enable  out  1  combinational redirect request
- br_late_target  out  32  combinational redirect target

## Operation
- **Bypass (combinational).**
  - fwd_valid is a register: regwrite_enable & ~memread_enable & ~squash of the previous ALU-stage instruction.
  - If fwd_valid and rd_index != 0 and rd_index == inst[25:21], A_raw = rd_value; else A_raw = rs_val. Same rule for rt: B_raw from rd_value or rt_val using inst[20:16].
  - Loads are never forwarded. Load-use spacing is the decoder's responsibility.
  - Distance-2 hazards are covered by regfile write-through, outside this block.
- **Operand B.** If const_override_rt, B = immediate, else B_raw. The immediate is zero-extended imm16 for ANDI/ORI/XORI and sign-extended otherwise. LUI gives imm16<<16.
- **Shift amount.** inst[10:6] if const_override_rs, else A_raw[4:0].
- **Ops.**
  - R-type funct: SLL/SRL/SRA/SLLV/SRLV/SRAV, ADD/ADDU/SUB/SUBU, AND/OR/XOR/NOR, SLT/SLTU, JR, JALR.
  - I-type: ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI, BEQ/BNE.
  - LW/SW result = A + sext(imm16), i.e. the address. JAL result = pc+8.
- **Destination.**
  - Neither override: inst[15:11].
  - rt_override_rd: inst[20:16].
  - rs_override_rd: inst[25:21].
  - Both: 31.
  - rd_index is forced to 0 when regwrite_enable = 0, squash = 1, or an exception occurs.
- **Late branch.** Asserted only when ~squash & ~rst.
  - BEQ taken (A == B_raw), BNE taken, JR, JALR.
  - Target = pc+4+(sext(imm16)<<2) for branches, A_raw for JR/JALR. JALR writes pc+8.
- **Exceptions.**
  - 3'b000 none.
  - 3'b001 signed overflow on ADD/ADDI/SUB.
  - 3'b010 unsupported opcode/funct.
  - 3'b100 JR/JALR target with A_raw[1:0] != 0. In this case no redirect is issued.
- **memop_disable.** Set to squash | (alu_exception != 0).

## Timing
- Bypass, ALU and branch logic are combinational within the cycle.
- br_late_* are valid in the same cycle as inst.
- rd_index, rd_value, rt_val_d1, memop_disable, alu_exception and fwd_valid update on posedge clk. They therefore have latency 1 and are aligned with MEM.
- On rst the registered outputs take these values:
  - rd_index = 0
  - rd_value = RESET_PC_LINK
  - rt_val_d1 = 0
  - alu_exception = 0
  - memop_disable = 1
  - fwd_valid = 0
- Reset mid-operation discards the in-flight result. The first instruction after reset sees no forwarding.
- Back-to-back dependent instructions forward every cycle with no stall.
- An rd_index of 0 never forwards.

## Structure
- Shared package: opcode/funct constants, exception codes, and the destination-select encoding.
- Sub-module delay_line, with parameters WIDTH, DEPTH (0 = wire) and RESET_VALUE, and ports clk, rst, d, q. DEPTH reset-to-RESET_VALUE registers.
  - All output registers are delay_line instances with DEPTH = 1.

## Test plan
- ADDU r3 = r1 + r2 (5 + 7), then SUBU r4 = r3 − r1 next cycle -> rd_value 12, then 7 via forwarding. rd_index 3, then 4.
- LW r5 followed by ADDU using r5 -> no forwarding; rs_val from the regfile is used. LW rd_value = base + sext(0xFFFC).
- ADD 0x7FFFFFFF + 1 -> alu_exception 001, rd_index 0, memop_disable 1.
- BEQ with A = B, pc = 0x100, imm = 3 -> br_late_enable 1, target 0x110. BNE with the same operands -> enable 0.
- JALR r31, r8 with r8 = 0x2002 -> exception 100, no redirect. With r8 = 0x2000 -> target 0x2000, rd_value = pc+8.
- squash = 1 on ORI -> rd_index 0, memop_disable 1, no forward to the next instruction. Assert rst -> all outputs reach their reset values next cycle.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared definitions for the MIPS execute stage.
// Holds the opcode and funct encodings the ALU decodes, the exception codes
// reported on alu_exception, the destination-select encoding formed from
// {rs_override_rd, rt_override_rd}, and the immediate-extension helper.
package execute_stage_pkg;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (inst[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Exception codes
    localparam logic [2:0] EXC_NONE        = 3'b000;
    localparam logic [2:0] EXC_OVERFLOW    = 3'b001;
    localparam logic [2:0] EXC_UNSUPPORTED = 3'b010;
    localparam logic [2:0] EXC_JR_ALIGN    = 3'b100;

    // Destination select, indexed by {rs_override_rd, rt_override_rd}
    typedef enum logic [1:0] {
        DST_RD = 2'b00,
        DST_RT = 2'b01,
        DST_RS = 2'b10,
        DST_RA = 2'b11
    } dst_sel_e;

    localparam logic [4:0] REG_RA = 5'd31;

    // Logical immediates are zero-extended, LUI is pre-shifted, all others
    // are sign-extended.
    function automatic logic [31:0] imm_operand(input logic [5:0] opcode,
                                                input logic [15:0] imm);
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: return {16'h0000, imm};
            OP_LUI:                   return {imm, 16'h0000};
            default:                  return {{16{imm[15]}}, imm};
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_delay_line.sv
// delay_line: DEPTH-stage register delay for side-band alignment.
// Ports: clk, rst (sync, active-high), d (WIDTH) in, q (WIDTH) out.
// DEPTH = 0 degenerates to a wire; every stage resets to RESET_VALUE.
module delay_line #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_regs
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            logic [WIDTH-1:0] q_r;
            if (g == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) q_r <= RESET_VALUE;
                    else     q_r <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) q_r <= RESET_VALUE;
                    else     q_r <= g_stage[g-1].q_r;
                end
            end
        end
        assign q = g_stage[DEPTH-1].q_r;
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: MIPS execute stage (bypass, ALU, late branch, destination).
// Inputs : clk, rst (sync, active-high), inst/pc of the ALU-stage instruction,
//          rs_val/rt_val regfile data, decoder controls (regwrite_enable,
//          memread_enable, rs/rt_override_rd, const_override_rs/rt), squash.
// Outputs: registered rd_index, rd_value, rt_val_d1, memop_disable,
//          alu_exception (aligned with MEM); combinational br_late_enable and
//          br_late_target for fetch redirect.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_LINK = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        regwrite_enable,
    input  logic        memread_enable,
    input  logic        rs_override_rd,
    input  logic        rt_override_rd,
    input  logic        const_override_rs,
    input  logic        const_override_rt,
    input  logic        squash,
    output logic [4:0]  rd_index,
    output logic [31:0] rd_value,
    output logic [31:0] rt_val_d1,
    output logic        memop_disable,
    output logic [2:0]  alu_exception,
    output logic        br_late_enable,
    output logic [31:0] br_late_target
);

    function automatic logic add_ovf(input logic signed [31:0] x, y, s);
        return (x[31] == y[31]) && (s[31] != x[31]);
    endfunction

    function automatic logic sub_ovf(input logic signed [31:0] x, y, d);
        return (x[31] != y[31]) && (d[31] != x[31]);
    endfunction

    logic [5:0]  opcode_p0, funct_p0;
    logic [4:0]  rs_idx_p0, rt_idx_p0, rd_fld_p0, sa_p0, dest_p0, rd_next_p0;
    logic [15:0] imm16_p0;
    logic [31:0] imm_sext_p0, a_raw_p0, b_raw_p0, b_op_p0, result_p0, pc_link_p0;
    logic signed [31:0] a_s_p0, b_s_p0, sum_p0, diff_p0;
    logic        fwd_valid, fwd_rs_p0, fwd_rt_p0;
    logic        ovf_p0, unsupported_p0, is_branch_p0, br_taken_p0, is_jr_p0;
    logic        misaligned_p0, memop_dis_p0, fwd_next_p0;
    logic [2:0]  exc_p0;
    dst_sel_e    dst_sel_p0;

    // ---- Stage p0: decode fields, bypass, operand selection ----
    assign opcode_p0   = inst[31:26];
    assign rs_idx_p0   = inst[25:21];
    assign rt_idx_p0   = inst[20:16];
    assign rd_fld_p0   = inst[15:11];
    assign funct_p0    = inst[5:0];
    assign imm16_p0    = inst[15:0];
    assign imm_sext_p0 = {{16{imm16_p0[15]}}, imm16_p0};
    assign pc_link_p0  = pc + 32'd8;

    // Only the previous instruction's result is forwarded; older results come
    // from the regfile via write-through. Register 0 is never forwarded.
    assign fwd_rs_p0 = fwd_valid && (rd_index != 5'd0) && (rd_index == rs_idx_p0);
    assign fwd_rt_p0 = fwd_valid && (rd_index != 5'd0) && (rd_index == rt_idx_p0);
    assign a_raw_p0  = fwd_rs_p0 ? rd_value : rs_val;
    assign b_raw_p0  = fwd_rt_p0 ? rd_value : rt_val;
    assign b_op_p0   = const_override_rt ? imm_operand(opcode_p0, imm16_p0) : b_raw_p0;
    assign sa_p0     = const_override_rs ? inst[10:6] : a_raw_p0[4:0];

    assign a_s_p0  = a_raw_p0;
    assign b_s_p0  = b_op_p0;
    assign sum_p0  = a_s_p0 + b_s_p0;
    assign diff_p0 = a_s_p0 - b_s_p0;

    always_comb begin
        result_p0      = '0;
        ovf_p0         = 1'b0;
        unsupported_p0 = 1'b0;
        is_branch_p0   = 1'b0;
        br_taken_p0    = 1'b0;
        is_jr_p0       = 1'b0;
        case (opcode_p0)
            OP_RTYPE: begin
                case (funct_p0)
                    FN_SLL, FN_SLLV: result_p0 = b_op_p0 << sa_p0;
                    FN_SRL, FN_SRLV: result_p0 = b_op_p0 >> sa_p0;
                    FN_SRA, FN_SRAV: result_p0 = b_s_p0 >>> sa_p0;
                    FN_ADD:  begin result_p0 = sum_p0;  ovf_p0 = add_ovf(a_s_p0, b_s_p0, sum_p0); end
                    FN_ADDU: result_p0 = sum_p0;
                    FN_SUB:  begin result_p0 = diff_p0; ovf_p0 = sub_ovf(a_s_p0, b_s_p0, diff_p0); end
                    FN_SUBU: result_p0 = diff_p0;
                    FN_AND:  result_p0 = a_raw_p0 & b_op_p0;
                    FN_OR:   result_p0 = a_raw_p0 | b_op_p0;
                    FN_XOR:  result_p0 = a_raw_p0 ^ b_op_p0;
                    FN_NOR:  result_p0 = ~(a_raw_p0 | b_op_p0);
                    FN_SLT:  result_p0 = {31'b0, a_s_p0 < b_s_p0};
                    FN_SLTU: result_p0 = {31'b0, a_raw_p0 < b_op_p0};
                    FN_JR, FN_JALR: begin is_jr_p0 = 1'b1; result_p0 = pc_link_p0; end
                    default: unsupported_p0 = 1'b1;
                endcase
            end
            OP_ADDI:  begin result_p0 = sum_p0; ovf_p0 = add_ovf(a_s_p0, b_s_p0, sum_p0); end
            OP_ADDIU: result_p0 = sum_p0;
            OP_SLTI:  result_p0 = {31'b0, a_s_p0 < b_s_p0};
            OP_SLTIU: result_p0 = {31'b0, a_raw_p0 < b_op_p0};
            OP_ANDI:  result_p0 = a_raw_p0 & b_op_p0;
            OP_ORI:   result_p0 = a_raw_p0 | b_op_p0;
            OP_XORI:  result_p0 = a_raw_p0 ^ b_op_p0;
            OP_LUI:   result_p0 = b_op_p0;
            OP_BEQ:   begin is_branch_p0 = 1'b1; br_taken_p0 = (a_raw_p0 == b_raw_p0); end
            OP_BNE:   begin is_branch_p0 = 1'b1; br_taken_p0 = (a_raw_p0 != b_raw_p0); end
            OP_LW, OP_SW: result_p0 = a_raw_p0 + imm_sext_p0;
            OP_JAL:   result_p0 = pc_link_p0;
            default:  unsupported_p0 = 1'b1;
        endcase
    end

    assign misaligned_p0 = is_jr_p0 && (a_raw_p0[1:0] != 2'b00);

    always_comb begin
        if (misaligned_p0)       exc_p0 = EXC_JR_ALIGN;
        else if (unsupported_p0) exc_p0 = EXC_UNSUPPORTED;
        else if (ovf_p0)         exc_p0 = EXC_OVERFLOW;
        else                     exc_p0 = EXC_NONE;
    end

    // A misaligned JR/JALR raises an exception instead of redirecting.
    assign br_late_enable = ~squash & ~rst &
                            ((is_branch_p0 & br_taken_p0) | (is_jr_p0 & ~misaligned_p0));
    assign br_late_target = is_jr_p0 ? a_raw_p0 : pc + 32'd4 + {imm_sext_p0[29:0], 2'b00};

    assign dst_sel_p0 = dst_sel_e'({rs_override_rd, rt_override_rd});
    always_comb begin
        case (dst_sel_p0)
            DST_RD:  dest_p0 = rd_fld_p0;
            DST_RT:  dest_p0 = rt_idx_p0;
            DST_RS:  dest_p0 = rs_idx_p0;
            default: dest_p0 = REG_RA;
        endcase
    end

    assign rd_next_p0   = (regwrite_enable && !squash && exc_p0 == EXC_NONE) ? dest_p0 : 5'd0;
    assign memop_dis_p0 = squash | (exc_p0 != EXC_NONE);
    assign fwd_next_p0  = regwrite_enable & ~memread_enable & ~squash;

    // ---- Stage p1: registered results aligned with MEM ----
    delay_line #(.WIDTH(5), .DEPTH(1), .RESET_VALUE(5'd0)) u_rd_index (
        .clk(clk), .rst(rst), .d(rd_next_p0), .q(rd_index));
    delay_line #(.WIDTH(32), .DEPTH(1), .RESET_VALUE(RESET_PC_LINK)) u_rd_value (
        .clk(clk), .rst(rst), .d(result_p0), .q(rd_value));
    delay_line #(.WIDTH(32), .DEPTH(1), .RESET_VALUE(32'd0)) u_rt_val (
        .clk(clk), .rst(rst), .d(b_raw_p0), .q(rt_val_d1));
    delay_line #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b1)) u_memop_dis (
        .clk(clk), .rst(rst), .d(memop_dis_p0), .q(memop_disable));
    delay_line #(.WIDTH(3), .DEPTH(1), .RESET_VALUE(EXC_NONE)) u_exc (
        .clk(clk), .rst(rst), .d(exc_p0), .q(alu_exception));
    delay_line #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b0)) u_fwd_valid (
        .clk(clk), .rst(rst), .d(fwd_next_p0), .q(fwd_valid));

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    localparam logic [31:0] RESET_LINK = 32'h0000_0BAD;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst, pc, rs_val, rt_val;
    logic        regwrite_enable, memread_enable, rs_override_rd, rt_override_rd;
    logic        const_override_rs, const_override_rt, squash;
    logic [4:0]  rd_index;
    logic [31:0] rd_value, rt_val_d1, br_late_target;
    logic        memop_disable, br_late_enable;
    logic [2:0]  alu_exception;

    execute_stage #(.RESET_PC_LINK(RESET_LINK)) dut (
        .clk(clk), .rst(rst), .inst(inst), .pc(pc), .rs_val(rs_val), .rt_val(rt_val),
        .regwrite_enable(regwrite_enable), .memread_enable(memread_enable),
        .rs_override_rd(rs_override_rd), .rt_override_rd(rt_override_rd),
        .const_override_rs(const_override_rs), .const_override_rt(const_override_rt),
        .squash(squash), .rd_index(rd_index), .rd_value(rd_value), .rt_val_d1(rt_val_d1),
        .memop_disable(memop_disable), .alu_exception(alu_exception),
        .br_late_enable(br_late_enable), .br_late_target(br_late_target));

    always #5 clk = ~clk;

    typedef enum int {
        K_SLL, K_SRL, K_SRA, K_SLLV, K_SRLV, K_SRAV, K_ADD, K_ADDU, K_SUB, K_SUBU,
        K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLTU, K_JR, K_JALR,
        K_ADDI, K_ADDIU, K_SLTI, K_SLTIU, K_ANDI, K_ORI, K_XORI, K_LUI,
        K_BEQ, K_BNE, K_LW, K_SW, K_JAL, K_BAD
    } kind_e;

    typedef struct {
        logic [4:0]  rd_index;
        logic [31:0] rd_value;
        bit          chk_value;
        logic [31:0] rt_val_d1;
        logic        memop;
        logic [2:0]  exc;
        int          id;
    } reg_exp_t;

    typedef struct {
        logic        en;
        logic [31:0] target;
        int          id;
    } br_exp_t;

    reg_exp_t    reg_q[$];
    br_exp_t     br_q[$];
    logic [31:0] regs[32];       // committed register file seen by rs_val/rt_val
    bit          pend_fwd;       // previous instruction's result is architecturally visible
    logic [4:0]  pend_idx;
    logic [31:0] pend_val;
    logic [4:0]  commit_idx;     // previous instruction's eventual regfile write
    logic [31:0] commit_val;
    int          n_checks = 0;
    int          n_pass = 0;
    int          seq = 0;

    function automatic logic [31:0] encode(kind_e k, logic [4:0] rs, logic [4:0] rt,
                                           logic [4:0] rd, logic [4:0] sh, logic [15:0] imm);
        logic [5:0] fn, op;
        fn = 6'h00;
        op = 6'h00;
        case (k)
            K_SLL: fn = 6'h00;  K_SRL: fn = 6'h02;  K_SRA: fn = 6'h03;
            K_SLLV: fn = 6'h04; K_SRLV: fn = 6'h06; K_SRAV: fn = 6'h07;
            K_JR: fn = 6'h08;   K_JALR: fn = 6'h09;
            K_ADD: fn = 6'h20;  K_ADDU: fn = 6'h21; K_SUB: fn = 6'h22; K_SUBU: fn = 6'h23;
            K_AND: fn = 6'h24;  K_OR: fn = 6'h25;   K_XOR: fn = 6'h26; K_NOR: fn = 6'h27;
            K_SLT: fn = 6'h2A;  K_SLTU: fn = 6'h2B;
            K_ADDI: op = 6'h08; K_ADDIU: op = 6'h09; K_SLTI: op = 6'h0A; K_SLTIU: op = 6'h0B;
            K_ANDI: op = 6'h0C; K_ORI: op = 6'h0D;   K_XORI: op = 6'h0E; K_LUI: op = 6'h0F;
            K_BEQ: op = 6'h04;  K_BNE: op = 6'h05;   K_LW: op = 6'h23;   K_SW: op = 6'h2B;
            K_JAL: op = 6'h03;
            default: if (imm[0]) op = 6'h02; else fn = 6'h18;  // J or MULT: not handled here
        endcase
        if (op == 6'h00) return {6'h00, rs, rt, rd, sh, fn};
        return {op, rs, rt, imm};
    endfunction

    task automatic check(string name, int id, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (instr %0d): got %h, expected %h", name, id, act, exp);
    endtask

    // Drive one instruction for one cycle and push the expected responses.
    task automatic issue(kind_e k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                         logic [4:0] sh, logic [15:0] imm, logic [31:0] p, bit sq, bit r);
        reg_exp_t    e;
        br_exp_t     b;
        logic [31:0] a, braw, bop, res, isx;
        logic [4:0]  sa, dst;
        logic [2:0]  exc;
        longint      wide;
        bit          taken, isjr, isbr, rw, mr, rsov, rtov, crs, crt, iimm;

        rw   = !(k inside {K_JR, K_BEQ, K_BNE, K_SW});
        mr   = (k == K_LW);
        iimm = (k >= K_ADDI && k <= K_LUI);
        rsov = (k == K_JAL);
        rtov = iimm || k == K_LW || k == K_JAL;
        crs  = (k inside {K_SLL, K_SRL, K_SRA});
        crt  = iimm || k == K_LW || k == K_SW;

        @(posedge clk);
        #2;
        rst = r; squash = sq; pc = p;
        inst = encode(k, rs, rt, rd, sh, imm);
        rs_val = regs[rs]; rt_val = regs[rt];
        regwrite_enable = rw; memread_enable = mr;
        rs_override_rd = rsov; rt_override_rd = rtov;
        const_override_rs = crs; const_override_rt = crt;

        // Architectural operand values: the newest write to the register.
        a    = (pend_fwd && pend_idx == rs) ? pend_val : regs[rs];
        braw = (pend_fwd && pend_idx == rt) ? pend_val : regs[rt];
        isx  = {{16{imm[15]}}, imm};
        case (k)
            K_ANDI, K_ORI, K_XORI: bop = {16'h0, imm};
            K_LUI:                 bop = {imm, 16'h0};
            default:               bop = iimm ? isx : braw;
        endcase
        sa = crs ? sh : a[4:0];

        res = 32'h0; exc = 3'b000; taken = 0; isjr = 0; isbr = 0;
        case (k)
            K_SLL, K_SLLV: res = braw << sa;
            K_SRL, K_SRLV: res = braw >> sa;
            K_SRA, K_SRAV: res = 32'($signed(braw) >>> sa);
            K_ADD, K_ADDI: begin
                wide = longint'($signed(a)) + longint'($signed(bop));
                res = a + bop;
                if (wide > 64'sd2147483647 || wide < -64'sd2147483648) exc = 3'b001;
            end
            K_SUB: begin
                wide = longint'($signed(a)) - longint'($signed(bop));
                res = a - bop;
                if (wide > 64'sd2147483647 || wide < -64'sd2147483648) exc = 3'b001;
            end
            K_ADDU, K_ADDIU: res = a + bop;
            K_SUBU: res = a - bop;
            K_AND, K_ANDI: res = a & bop;
            K_OR, K_ORI: res = a | bop;
            K_XOR, K_XORI: res = a ^ bop;
            K_NOR: res = ~(a | bop);
            K_SLT, K_SLTI: res = ($signed(a) < $signed(bop)) ? 32'd1 : 32'd0;
            K_SLTU, K_SLTIU: res = (a < bop) ? 32'd1 : 32'd0;
            K_LUI: res = bop;
            K_JR, K_JALR: begin
                isjr = 1; res = p + 32'd8;
                if (a[1:0] != 2'b00) exc = 3'b100;
            end
            K_BEQ: begin isbr = 1; taken = (a == braw); end
            K_BNE: begin isbr = 1; taken = (a != braw); end
            K_LW, K_SW: res = a + isx;
            K_JAL: res = p + 32'd8;
            default: exc = 3'b010;
        endcase

        if (k == K_JAL) dst = 5'd31;
        else if (rtov)  dst = rt;
        else            dst = rd;

        e.id = seq; b.id = seq; seq++;
        if (r) begin
            e.rd_index = 5'd0; e.rd_value = RESET_LINK; e.chk_value = 1;
            e.rt_val_d1 = 32'd0; e.memop = 1'b1; e.exc = 3'b000;
            b.en = 1'b0; b.target = 32'd0;
        end else begin
            e.rd_index  = (rw && !sq && exc == 3'b000) ? dst : 5'd0;
            e.rd_value  = res;
            e.chk_value = (e.rd_index != 5'd0) || (k == K_SW && !sq);
            e.rt_val_d1 = braw;
            e.memop     = sq || (exc != 3'b000);
            e.exc       = exc;
            b.en        = !sq && ((isbr && taken) || (isjr && exc == 3'b000));
            b.target    = isjr ? a : p + 32'd4 + (isx << 2);
        end
        reg_q.push_back(e);
        br_q.push_back(b);

        // Retire the previous instruction into the regfile, then track this one.
        if (commit_idx != 5'd0) regs[commit_idx] = commit_val;
        if (r) begin
            pend_fwd = 0; pend_idx = 5'd0; pend_val = 32'd0;
            commit_idx = 5'd0; commit_val = 32'd0;
        end else begin
            pend_fwd   = rw && !mr && !sq && (e.rd_index != 5'd0);
            pend_idx   = e.rd_index;
            pend_val   = res;
            commit_idx = e.rd_index;
            commit_val = mr ? $urandom : res;
        end
    endtask

    initial begin : monitor
        reg_exp_t e;
        br_exp_t  b;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                check("rd_index", e.id, 32'(rd_index), 32'(e.rd_index));
                if (e.chk_value) check("rd_value", e.id, rd_value, e.rd_value);
                check("rt_val_d1", e.id, rt_val_d1, e.rt_val_d1);
                check("memop_disable", e.id, 32'(memop_disable), 32'(e.memop));
                check("alu_exception", e.id, 32'(alu_exception), 32'(e.exc));
            end
            @(negedge clk);
            if (br_q.size() > 0) begin
                b = br_q.pop_front();
                check("br_late_enable", b.id, 32'(br_late_enable), 32'(b.en));
                if (b.en) check("br_late_target", b.id, br_late_target, b.target);
            end
        end
    end

    initial begin : driver
        kind_e k;
        rst = 1'b1; squash = 1'b0; inst = 32'h0; pc = 32'h0; rs_val = 32'h0; rt_val = 32'h0;
        regwrite_enable = 0; memread_enable = 0; rs_override_rd = 0; rt_override_rd = 0;
        const_override_rs = 0; const_override_rt = 0;
        pend_fwd = 0; pend_idx = 5'd0; pend_val = 32'd0; commit_idx = 5'd0; commit_val = 32'd0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;

        issue(K_ADDU, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 0, 1);
        issue(K_ADDU, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 0, 1);

        regs[1] = 32'd5; regs[2] = 32'd7; regs[3] = 32'hDEAD_0003;
        regs[5] = 32'd100; regs[9] = 32'h7FFF_FFFF; regs[10] = 32'd1;
        regs[12] = 32'h55; regs[13] = 32'h55; regs[14] = 32'h1234;

        // ADDU r3=r1+r2 then SUBU r4=r3-r1 via forwarding
        issue(K_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h40, 0, 0);
        issue(K_SUBU, 5'd3, 5'd1, 5'd4, 5'd0, 16'h0, 32'h44, 0, 0);
        // LW r5, -4(r1); ADDU r6=r5+r2 must use the stale regfile value
        issue(K_LW, 5'd1, 5'd5, 5'd0, 5'd0, 16'hFFFC, 32'h48, 0, 0);
        issue(K_ADDU, 5'd5, 5'd2, 5'd6, 5'd0, 16'h0, 32'h4C, 0, 0);
        // signed overflow
        issue(K_ADD, 5'd9, 5'd10, 5'd11, 5'd0, 16'h0, 32'h50, 0, 0);
        // BEQ taken / BNE not taken
        issue(K_BEQ, 5'd12, 5'd13, 5'd0, 5'd0, 16'd3, 32'h100, 0, 0);
        issue(K_BNE, 5'd12, 5'd13, 5'd0, 5'd0, 16'd3, 32'h100, 0, 0);
        // JALR r31, r8 misaligned then aligned
        regs[8] = 32'h2002;
        issue(K_JALR, 5'd8, 5'd0, 5'd31, 5'd0, 16'h0, 32'h400, 0, 0);
        regs[8] = 32'h2000;
        issue(K_JALR, 5'd8, 5'd0, 5'd31, 5'd0, 16'h0, 32'h404, 0, 0);
        // squashed ORI r14 does not forward to the next ADDU
        issue(K_ORI, 5'd1, 5'd14, 5'd0, 5'd0, 16'h00F0, 32'h408, 1, 0);
        issue(K_ADDU, 5'd14, 5'd2, 5'd15, 5'd0, 16'h0, 32'h40C, 0, 0);
        // reset in the middle of a dependent pair
        issue(K_ADDIU, 5'd1, 5'd16, 5'd0, 5'd0, 16'h0010, 32'h410, 0, 0);
        issue(K_ADDU, 5'd16, 5'd16, 5'd17, 5'd0, 16'h0, 32'h414, 0, 1);
        issue(K_ADDU, 5'd16, 5'd2, 5'd18, 5'd0, 16'h0, 32'h418, 0, 0);

        // Randomized traffic on a small register window for dense hazards
        for (int i = 1; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0: regs[i] = 32'h7FFF_FFFF;
                1: regs[i] = 32'h8000_0000;
                default: regs[i] = $urandom;
            endcase
        end
        for (int n = 0; n < 500; n++) begin
            k = kind_e'($urandom_range(0, int'(K_BAD)));
            issue(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom), 16'($urandom),
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
        end

        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (reg_q.size() == 0 && br_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d/%0d pending, expected 0/0", reg_q.size(), br_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
